apa102_strand_scheduler: RTL and testbench

//  Time-shares one APA102 frame serializer among NSTRANDS LED strands (lanterns, rain strands).

---
 rtl/apa102_strand_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_apa102_strand_scheduler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apa102_strand_scheduler.sv
// Round-robin scheduler that time-shares one APA102 frame serializer among several LED strands.
// Each granted strand receives a start frame, its LED words fetched on demand, and an end frame.
module apa102_strand_scheduler #(
    parameter int NSTRANDS = 3,
    parameter int MAXLEDS  = 14,
    parameter int LENW     = 5,
    parameter int SCK_DIV  = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NSTRANDS-1:0]      req,
    input  logic [NSTRANDS*LENW-1:0] len,
    input  logic [31:0]              led_data,
    output logic [NSTRANDS-1:0]      led_sel,
    output logic [LENW-1:0]          led_idx,
    output logic [NSTRANDS-1:0]      grant,
    output logic                     busy,
    output logic [NSTRANDS-1:0]      done,
    output logic [NSTRANDS-1:0]      sck_o,
    output logic [NSTRANDS-1:0]      mosi_o
);

    localparam int HALF = SCK_DIV / 2;
    localparam int DIVW = $clog2(SCK_DIV);
    localparam int PTRW = (NSTRANDS > 1) ? $clog2(NSTRANDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_LED,
        S_END
    } state_t;

    state_t              state_q, state_d;
    logic [PTRW-1:0]     ptr_q, ptr_d;
    logic [NSTRANDS-1:0] grant_q, grant_d;
    logic                busy_q, busy_d;
    logic [NSTRANDS-1:0] done_q, done_d;
    logic [NSTRANDS-1:0] sck_q, sck_d;
    logic [NSTRANDS-1:0] mosi_q, mosi_d;
    logic [LENW-1:0]     led_idx_q, led_idx_d;
    logic [LENW-1:0]     len_q, len_d;
    logic [LENW-1:0]     word_q, word_d;
    logic [4:0]          bit_q, bit_d;
    logic [DIVW-1:0]     div_q, div_d;
    logic [31:0]         shreg_q, shreg_d;
    logic                fetch_q, fetch_d;

    logic                found;
    logic [PTRW-1:0]     pick;
    logic [LENW-1:0]     pick_len;
    logic [LENW-1:0]     clamp_len;
    int                  idx;

    // Rotating-priority search: first requester at or after the pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < NSTRANDS; k++) begin
            idx = (int'(ptr_q) + k) % NSTRANDS;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = PTRW'(idx);
            end
        end
        pick_len  = len[pick*LENW +: LENW];
        clamp_len = (pick_len > LENW'(MAXLEDS)) ? LENW'(MAXLEDS) : pick_len;
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        done_d    = '0;
        led_idx_d = led_idx_q;
        len_d     = len_q;
        word_d    = word_q;
        bit_d     = bit_q;
        div_d     = div_q;
        shreg_d   = shreg_q;
        fetch_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                grant_d   = '0;
                busy_d    = 1'b0;
                led_idx_d = '0;
                if (found) begin
                    state_d = S_START;
                    grant_d = NSTRANDS'(1) << pick;
                    busy_d  = 1'b1;
                    len_d   = clamp_len;
                    ptr_d   = (int'(pick) == NSTRANDS - 1) ? '0 : pick + 1'b1;
                    div_d   = '0;
                    bit_d   = '0;
                    word_d  = '0;
                    shreg_d = '0;
                end
            end
            default: begin
                // The index advances one cycle after its word was captured, so the source
                // has a whole word time to present the next one.
                if (fetch_q && led_idx_q != len_q - 1'b1) begin
                    led_idx_d = led_idx_q + 1'b1;
                end
                if (int'(div_q) != SCK_DIV - 1) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (bit_q != 5'd31) begin
                        bit_d   = bit_q + 1'b1;
                        shreg_d = {shreg_q[30:0], 1'b0};
                    end else begin
                        bit_d = '0;
                        case (state_q)
                            S_START: begin
                                if (len_q == '0) begin
                                    state_d = S_END;
                                    shreg_d = '1;
                                end else begin
                                    state_d = S_LED;
                                    word_d  = '0;
                                    shreg_d = led_data;
                                    fetch_d = 1'b1;
                                end
                            end
                            S_LED: begin
                                if (word_q == len_q - 1'b1) begin
                                    state_d = S_END;
                                    shreg_d = '1;
                                end else begin
                                    word_d  = word_q + 1'b1;
                                    shreg_d = led_data;
                                    fetch_d = 1'b1;
                                end
                            end
                            default: begin
                                state_d   = S_IDLE;
                                grant_d   = '0;
                                busy_d    = 1'b0;
                                done_d    = grant_q;
                                led_idx_d = '0;
                            end
                        endcase
                    end
                end
            end
        endcase

        // Pins follow the next-state values so they are registered alongside the FSM.
        sck_d  = (state_d != S_IDLE && int'(div_d) >= HALF) ? grant_d : '0;
        mosi_d = (state_d != S_IDLE && shreg_d[31]) ? grant_d : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= '0;
            sck_q     <= '0;
            mosi_q    <= '0;
            led_idx_q <= '0;
            len_q     <= '0;
            word_q    <= '0;
            bit_q     <= '0;
            div_q     <= '0;
            shreg_q   <= '0;
            fetch_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            led_idx_q <= led_idx_d;
            len_q     <= len_d;
            word_q    <= word_d;
            bit_q     <= bit_d;
            div_q     <= div_d;
            shreg_q   <= shreg_d;
            fetch_q   <= fetch_d;
        end
    end

    assign led_sel = grant_q;
    assign grant   = grant_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign sck_o   = sck_q;
    assign mosi_o  = mosi_q;
    assign led_idx = led_idx_q;

endmodule

// File: tb/tb_apa102_strand_scheduler.sv
// Directed self-checking bench for apa102_strand_scheduler with SCK_DIV=4 and three strands.
module tb_apa102_strand_scheduler;

    localparam int NS      = 3;
    localparam int LENW    = 5;
    localparam int SCK_DIV = 4;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NS-1:0]        req;
    logic [NS*LENW-1:0]   len;
    logic [31:0]          led_data;
    logic [NS-1:0]        led_sel;
    logic [LENW-1:0]      led_idx;
    logic [NS-1:0]        grant;
    logic                 busy;
    logic [NS-1:0]        done;
    logic [NS-1:0]        sck_o;
    logic [NS-1:0]        mosi_o;

    int   total = 0;
    int   bad   = 0;
    logic cap_bits [0:1023];
    int   nbits;
    int   done_n;
    int   idx_max;
    int   idx_changes;
    logic other_act;
    logic idx_jump;
    logic led_mode;
    logic [31:0] exp_w [0:17];
    int   nwords;

    apa102_strand_scheduler #(
        .NSTRANDS(NS),
        .MAXLEDS (14),
        .LENW    (LENW),
        .SCK_DIV (SCK_DIV)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .len     (len),
        .led_data(led_data),
        .led_sel (led_sel),
        .led_idx (led_idx),
        .grant   (grant),
        .busy    (busy),
        .done    (done),
        .sck_o   (sck_o),
        .mosi_o  (mosi_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] model(input logic [LENW-1:0] k);
        logic [7:0] k8;
        k8 = {3'b000, k};
        return {3'b111, k, k8 * 8'd3, 8'hC3, ~k8};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Follows one frame on strand s from the grant cycle, capturing mosi at each sck rise.
    task automatic watch_frame(input int s, input int limit, input int ev_n,
                               input logic [31:0] ev_data, input int len_n,
                               input logic [LENW-1:0] len_val);
        logic           prev_sck;
        logic [LENW-1:0] prev_idx;
        nbits       = 0;
        done_n      = -1;
        idx_max     = 0;
        idx_changes = 0;
        other_act   = 1'b0;
        idx_jump    = 1'b0;
        prev_sck    = sck_o[s];
        prev_idx    = led_idx;
        for (int n = 1; n <= limit; n++) begin
            tick();
            if (n == ev_n) led_data = ev_data;
            if (n == len_n) len[s*LENW +: LENW] = len_val;
            if (led_mode) led_data = model(led_idx);
            if (sck_o[s] && !prev_sck && nbits < 1024) begin
                cap_bits[nbits] = mosi_o[s];
                nbits++;
            end
            prev_sck = sck_o[s];
            if (((sck_o | mosi_o) & ~(NS'(1) << s)) != '0) other_act = 1'b1;
            if (done[s]) begin
                done_n = n;
                break;
            end
            if (led_idx != prev_idx) begin
                if (led_idx != prev_idx + 1'b1) idx_jump = 1'b1;
                idx_changes++;
                prev_idx = led_idx;
            end
            if (int'(led_idx) > idx_max) idx_max = int'(led_idx);
        end
    endtask

    task automatic check_frame(input string tag, input int exp_done);
        int          mism;
        logic [31:0] w;
        mism = 0;
        for (int i = 0; i < nbits; i++) begin
            if (i / 32 < nwords) begin
                w = exp_w[i / 32];
                if (cap_bits[i] !== w[31 - (i % 32)]) mism++;
            end
        end
        check({tag, "_done_cycle"}, 64'(done_n), 64'(exp_done));
        check({tag, "_bit_count"}, 64'(nbits), 64'(nwords * 32));
        check({tag, "_bit_errors"}, 64'(mism), 64'd0);
    endtask

    initial begin
        reset_n  = 1'b0;
        req      = '0;
        len      = '0;
        led_data = '0;
        led_mode = 1'b0;
        tick();
        tick();
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pins", 64'({sck_o, mosi_o, done}), 64'd0);
        check("rst_led_idx", 64'(led_idx), 64'd0);
        reset_n = 1'b1;
        tick();

        // Two LED words on strand 0
        len[0 +: LENW] = 5'd2;
        led_data = 32'hE10000FF;
        req = 3'b001;
        tick();
        check("t1_grant", 64'(grant), 64'b001);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_led_sel", 64'(led_sel), 64'b001);
        check("t1_sck_at_grant", 64'(sck_o), 64'd0);
        req = 3'b000;
        watch_frame(0, 600, -1, 32'h0, -1, 5'd0);
        nwords = 4;
        exp_w[0] = 32'h0;
        exp_w[1] = 32'hE10000FF;
        exp_w[2] = 32'hE10000FF;
        exp_w[3] = 32'hFFFFFFFF;
        check_frame("t1", 512);
        check("t1_other_flat", 64'(other_act), 64'd0);
        check("t1_done", 64'(done), 64'b001);
        check("t1_grant_after", 64'(grant), 64'd0);
        check("t1_busy_after", 64'(busy), 64'd0);
        check("t1_idx_max", 64'(idx_max), 64'd1);
        check("t1_idx_idle", 64'(led_idx), 64'd0);
        tick();
        check("t1_no_regrant", 64'(grant), 64'd0);
        check("t1_done_pulse", 64'(done), 64'd0);

        // Round-robin order with all strands requesting continuously
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        len = {5'd1, 5'd1, 5'd1};
        led_data = 32'hE1000000;
        req = 3'b111;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("t2_grant_order", 64'(grant), 64'(NS'(1) << (k % NS)));
            watch_frame(k % NS, 500, -1, 32'h0, -1, 5'd0);
            check("t2_done_cycle", 64'(done_n), 64'd384);
            check("t2_done_bit", 64'(done), 64'(NS'(1) << (k % NS)));
            check("t2_idle_gap", 64'(grant), 64'd0);
            if (k == 4) req = 3'b000;
            tick();
        end
        check("t2_final_idle", 64'(grant), 64'd0);

        // Zero-length frame
        len[0 +: LENW] = 5'd0;
        req = 3'b001;
        tick();
        check("t3_grant", 64'(grant), 64'b001);
        req = 3'b000;
        watch_frame(0, 400, -1, 32'h0, -1, 5'd0);
        nwords = 2;
        exp_w[0] = 32'h0;
        exp_w[1] = 32'hFFFFFFFF;
        check_frame("t3", 256);
        check("t3_idx_max", 64'(idx_max), 64'd0);
        tick();

        // Length beyond MAXLEDS is clamped
        len[0 +: LENW] = 5'd20;
        led_mode = 1'b1;
        led_data = model(5'd0);
        req = 3'b001;
        tick();
        check("t4_grant", 64'(grant), 64'b001);
        req = 3'b000;
        watch_frame(0, 2200, -1, 32'h0, -1, 5'd0);
        led_mode = 1'b0;
        nwords = 16;
        exp_w[0] = 32'h0;
        for (int k = 0; k < 14; k++) exp_w[k + 1] = model(LENW'(k));
        exp_w[15] = 32'hFFFFFFFF;
        check_frame("t4", 2048);
        check("t4_idx_max", 64'(idx_max), 64'd13);
        check("t4_idx_steps", 64'(idx_changes), 64'd13);
        check("t4_idx_jump", 64'(idx_jump), 64'd0);
        tick();

        // Late changes to led_data and len do not disturb the frame in flight
        len[0 +: LENW] = 5'd2;
        led_data = 32'hE1123456;
        req = 3'b001;
        tick();
        check("t6_grant", 64'(grant), 64'b001);
        req = 3'b000;
        watch_frame(0, 600, 130, 32'hE1ABCDEF, 200, 5'd10);
        nwords = 4;
        exp_w[0] = 32'h0;
        exp_w[1] = 32'hE1123456;
        exp_w[2] = 32'hE1ABCDEF;
        exp_w[3] = 32'hFFFFFFFF;
        check_frame("t6", 512);
        tick();

        // Asynchronous reset in the middle of a frame
        len = {5'd1, 5'd1, 5'd5};
        led_data = 32'hE1555555;
        req = 3'b001;
        tick();
        check("t5_grant", 64'(grant), 64'b001);
        req = 3'b000;
        watch_frame(0, 532, -1, 32'h0, -1, 5'd0);
        check("t5_mid_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("t5_rst_grant", 64'(grant), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_pins", 64'({sck_o, mosi_o, done}), 64'd0);
        check("t5_rst_idx", 64'({led_idx, led_sel}), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        len = {5'd1, 5'd1, 5'd1};
        req = 3'b101;
        tick();
        check("t5_ptr_restart", 64'(grant), 64'b001);
        req = 3'b000;
        watch_frame(0, 500, -1, 32'h0, -1, 5'd0);
        check("t5_first_done", 64'(done_n), 64'd384);
        tick();
        req = 3'b010;
        tick();
        check("t5_grant1", 64'(grant), 64'b010);
        req = 3'b000;
        watch_frame(1, 500, -1, 32'h0, -1, 5'd0);
        nwords = 3;
        exp_w[0] = 32'h0;
        exp_w[1] = 32'hE1555555;
        exp_w[2] = 32'hFFFFFFFF;
        check_frame("t5_s1", 384);
        check("t5_other_flat", 64'(other_act), 64'd0);
        check("t5_done1", 64'(done), 64'b010);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
